ysyx_24100006_axi_demux: RTL

- Parametrised AXI4 1-master-to-N-slave router sitting between the ysyx_24100006 core master port and its memory and peripheral slaves (mem, UART, and future devices).
- Replaces ad-hoc combinational address steering. Each transaction's route is latched at address acceptance, so the slave selection cannot change mid-burst.
- Read and write paths are independent. Each allows one outstanding transaction.
- Unmapped addresses get a full-length DECERR response generated internally.

---
 rtl/ysyx_24100006_axi_pkg.sv | 33 +++
 rtl/ysyx_24100006_axi_addr_dec.sv | 27 ++
 rtl/ysyx_24100006_axi_demux.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_24100006_axi_pkg.sv
// Shared types and constants for the ysyx_24100006 AXI4 1-to-N router.
package ysyx_24100006_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Address width carried in the registered AR/AW payload.
  localparam int AXI_ADDR_W = 32;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA,
    R_ERR
  } r_state_e;

  typedef enum logic [2:0] {
    W_IDLE,
    W_ADDR,
    W_DATA,
    W_RESP,
    W_ERR_DATA,
    W_ERR_RESP
  } w_state_e;

  typedef struct packed {
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } ax_req_t;

endpackage

// File: rtl/ysyx_24100006_axi_addr_dec.sv
// Combinational mask/base address matcher; lowest matching slave index wins.
module ysyx_24100006_axi_addr_dec #(
  parameter int                      N_SLV    = 2,
  parameter int                      ADDR_W   = 32,
  parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = '0,
  parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK = '0
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic [N_SLV-1:0]  sel_o,
  output logic              err_o
);

  logic found;

  always_comb begin
    sel_o = '0;
    found = 1'b0;
    for (int i = 0; i < N_SLV; i++) begin
      if (!found && ((addr_i & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W])) begin
        sel_o[i] = 1'b1;
        found    = 1'b1;
      end
    end
    err_o = !found;
  end

endmodule

// File: rtl/ysyx_24100006_axi_demux.sv
// AXI4 1-master-to-N-slave router; the route is latched at address acceptance
// so a burst can never be re-steered. Unmapped accesses get an internal DECERR.
module ysyx_24100006_axi_demux
  import ysyx_24100006_axi_pkg::*;
#(
  parameter int                      N_SLV    = 2,
  parameter int                      ADDR_W   = 32,
  parameter int                      DATA_W   = 32,
  parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = {32'ha000_03f8, 32'h8000_0000},
  parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK = {32'hffff_fff8, 32'hf800_0000}
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       m_arvalid,
  output logic                       m_arready,
  input  logic [ADDR_W-1:0]          m_araddr,
  input  logic [7:0]                 m_arlen,
  input  logic [2:0]                 m_arsize,
  input  logic [1:0]                 m_arburst,
  output logic                       m_rvalid,
  input  logic                       m_rready,
  output logic [DATA_W-1:0]          m_rdata,
  output logic [1:0]                 m_rresp,
  output logic                       m_rlast,
  input  logic                       m_awvalid,
  output logic                       m_awready,
  input  logic [ADDR_W-1:0]          m_awaddr,
  input  logic [7:0]                 m_awlen,
  input  logic [2:0]                 m_awsize,
  input  logic [1:0]                 m_awburst,
  input  logic                       m_wvalid,
  output logic                       m_wready,
  input  logic [DATA_W-1:0]          m_wdata,
  input  logic [DATA_W/8-1:0]        m_wstrb,
  input  logic                       m_wlast,
  output logic                       m_bvalid,
  input  logic                       m_bready,
  output logic [1:0]                 m_bresp,
  output logic [N_SLV-1:0]           s_arvalid,
  input  logic [N_SLV-1:0]           s_arready,
  output logic [N_SLV*ADDR_W-1:0]    s_araddr,
  output logic [N_SLV*8-1:0]         s_arlen,
  output logic [N_SLV*3-1:0]         s_arsize,
  output logic [N_SLV*2-1:0]         s_arburst,
  input  logic [N_SLV-1:0]           s_rvalid,
  output logic [N_SLV-1:0]           s_rready,
  input  logic [N_SLV*DATA_W-1:0]    s_rdata,
  input  logic [N_SLV*2-1:0]         s_rresp,
  input  logic [N_SLV-1:0]           s_rlast,
  output logic [N_SLV-1:0]           s_awvalid,
  input  logic [N_SLV-1:0]           s_awready,
  output logic [N_SLV*ADDR_W-1:0]    s_awaddr,
  output logic [N_SLV*8-1:0]         s_awlen,
  output logic [N_SLV*3-1:0]         s_awsize,
  output logic [N_SLV*2-1:0]         s_awburst,
  output logic [N_SLV-1:0]           s_wvalid,
  input  logic [N_SLV-1:0]           s_wready,
  output logic [N_SLV*DATA_W-1:0]    s_wdata,
  output logic [N_SLV*DATA_W/8-1:0]  s_wstrb,
  output logic [N_SLV-1:0]           s_wlast,
  input  logic [N_SLV-1:0]           s_bvalid,
  output logic [N_SLV-1:0]           s_bready,
  input  logic [N_SLV*2-1:0]         s_bresp
);

  localparam int STRB_W = DATA_W / 8;

  r_state_e         r_state_q, r_state_d;
  w_state_e         w_state_q, w_state_d;
  ax_req_t          ar_q, ar_d, aw_q, aw_d;
  logic [N_SLV-1:0] r_sel_q, r_sel_d, w_sel_q, w_sel_d;
  logic [7:0]       r_cnt_q, r_cnt_d;
  logic [N_SLV-1:0] ar_sel, aw_sel;
  logic             ar_err, aw_err;

  ysyx_24100006_axi_addr_dec #(
    .N_SLV(N_SLV), .ADDR_W(ADDR_W), .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK)
  ) u_ar_dec (
    .addr_i(m_araddr), .sel_o(ar_sel), .err_o(ar_err)
  );

  ysyx_24100006_axi_addr_dec #(
    .N_SLV(N_SLV), .ADDR_W(ADDR_W), .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK)
  ) u_aw_dec (
    .addr_i(m_awaddr), .sel_o(aw_sel), .err_o(aw_err)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state_q <= R_IDLE;
      w_state_q <= W_IDLE;
      ar_q      <= '0;
      aw_q      <= '0;
      r_sel_q   <= '0;
      w_sel_q   <= '0;
      r_cnt_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      w_state_q <= w_state_d;
      ar_q      <= ar_d;
      aw_q      <= aw_d;
      r_sel_q   <= r_sel_d;
      w_sel_q   <= w_sel_d;
      r_cnt_q   <= r_cnt_d;
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    ar_d      = ar_q;
    r_sel_d   = r_sel_q;
    r_cnt_d   = r_cnt_q;
    m_arready = 1'b0;
    m_rvalid  = 1'b0;
    m_rdata   = '0;
    m_rresp   = RESP_OKAY;
    m_rlast   = 1'b0;
    s_arvalid = '0;
    s_rready  = '0;
    for (int i = 0; i < N_SLV; i++) begin
      s_araddr[i*ADDR_W +: ADDR_W] = r_sel_q[i] ? ADDR_W'(ar_q.addr) : '0;
      s_arlen[i*8 +: 8]            = r_sel_q[i] ? ar_q.len : '0;
      s_arsize[i*3 +: 3]           = r_sel_q[i] ? ar_q.size : '0;
      s_arburst[i*2 +: 2]          = r_sel_q[i] ? ar_q.burst : '0;
    end
    case (r_state_q)
      R_IDLE: begin
        m_arready = !reset;
        if (m_arvalid && !reset) begin
          ar_d    = '{addr: AXI_ADDR_W'(m_araddr), len: m_arlen, size: m_arsize, burst: m_arburst};
          r_sel_d = ar_sel;
          if (ar_err) begin
            r_state_d = R_ERR;
            r_cnt_d   = m_arlen;
          end else begin
            r_state_d = R_ADDR;
          end
        end
      end
      R_ADDR: begin
        s_arvalid = r_sel_q;
        if (|(s_arready & r_sel_q)) r_state_d = R_DATA;
      end
      R_DATA: begin
        for (int i = 0; i < N_SLV; i++) begin
          if (r_sel_q[i]) begin
            m_rvalid = s_rvalid[i];
            m_rdata  = s_rdata[i*DATA_W +: DATA_W];
            m_rresp  = s_rresp[i*2 +: 2];
            m_rlast  = s_rlast[i];
          end
        end
        s_rready = r_sel_q & {N_SLV{m_rready}};
        if (m_rvalid && m_rready && m_rlast) r_state_d = R_IDLE;
      end
      R_ERR: begin
        m_rvalid = 1'b1;
        m_rresp  = RESP_DECERR;
        m_rlast  = (r_cnt_q == 8'd0);
        if (m_rready) begin
          if (m_rlast) r_state_d = R_IDLE;
          else         r_cnt_d   = r_cnt_q - 8'd1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Write path: W beats are held off until AW has been routed to its slave.
  always_comb begin
    w_state_d = w_state_q;
    aw_d      = aw_q;
    w_sel_d   = w_sel_q;
    m_awready = 1'b0;
    m_wready  = 1'b0;
    m_bvalid  = 1'b0;
    m_bresp   = RESP_OKAY;
    s_awvalid = '0;
    s_wvalid  = '0;
    s_bready  = '0;
    for (int i = 0; i < N_SLV; i++) begin
      s_awaddr[i*ADDR_W +: ADDR_W] = w_sel_q[i] ? ADDR_W'(aw_q.addr) : '0;
      s_awlen[i*8 +: 8]            = w_sel_q[i] ? aw_q.len : '0;
      s_awsize[i*3 +: 3]           = w_sel_q[i] ? aw_q.size : '0;
      s_awburst[i*2 +: 2]          = w_sel_q[i] ? aw_q.burst : '0;
      s_wdata[i*DATA_W +: DATA_W]  = (w_sel_q[i] && w_state_q == W_DATA) ? m_wdata : '0;
      s_wstrb[i*STRB_W +: STRB_W]  = (w_sel_q[i] && w_state_q == W_DATA) ? m_wstrb : '0;
      s_wlast[i]                   = w_sel_q[i] && w_state_q == W_DATA && m_wlast;
    end
    case (w_state_q)
      W_IDLE: begin
        m_awready = !reset;
        if (m_awvalid && !reset) begin
          aw_d      = '{addr: AXI_ADDR_W'(m_awaddr), len: m_awlen, size: m_awsize, burst: m_awburst};
          w_sel_d   = aw_sel;
          w_state_d = aw_err ? W_ERR_DATA : W_ADDR;
        end
      end
      W_ADDR: begin
        s_awvalid = w_sel_q;
        if (|(s_awready & w_sel_q)) w_state_d = W_DATA;
      end
      W_DATA: begin
        s_wvalid = w_sel_q & {N_SLV{m_wvalid}};
        m_wready = |(s_wready & w_sel_q);
        if (m_wvalid && m_wready && m_wlast) w_state_d = W_RESP;
      end
      W_RESP: begin
        for (int i = 0; i < N_SLV; i++) begin
          if (w_sel_q[i]) begin
            m_bvalid = s_bvalid[i];
            m_bresp  = s_bresp[i*2 +: 2];
          end
        end
        s_bready = w_sel_q & {N_SLV{m_bready}};
        if (m_bvalid && m_bready) w_state_d = W_IDLE;
      end
      W_ERR_DATA: begin
        m_wready = 1'b1;
        if (m_wvalid && m_wlast) w_state_d = W_ERR_RESP;
      end
      W_ERR_RESP: begin
        m_bvalid = 1'b1;
        m_bresp  = RESP_DECERR;
        if (m_bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

endmodule
